// File: rtl/mac_drain_pkg.sv
// rtl/mac_drain_pkg.sv - shared types and defaults for the MAC accumulate-and-drain block
package mac_drain_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // One FIFO entry: {overflow flag, 32-bit accumulator value}
    localparam int ENTRY_W = 33;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/mac_res_fifo.sv
// rtl/mac_res_fifo.sv - synchronous result FIFO with push-at-full allowed when a pop frees the slot
module mac_res_fifo
    import mac_drain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          rd_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_en   = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push at full still fits.
    assign push_ok = push && (!full || rd_en);
    // Head reads zero while empty so the consumer side sees a clean reset value.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_accum_drain.sv
// rtl/mac_accum_drain.sv - sequences one dot product on an external 16-bit MAC and queues the result
module mac_accum_drain
    import mac_drain_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      acc_in,
    input  logic             acc_cout,
    output logic             mac_clr,
    output logic             op_gate,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_ovf,
    output logic             drop_err
);

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               ovf;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    // Outputs toward the MAC are pure decodes of the registered state.
    assign mac_clr = (state == ST_CLEAR);
    assign op_gate = (state == ST_RUN);
    assign busy    = (state != ST_IDLE);

    assign push      = (state == ST_CAPTURE);
    assign pop       = res_valid && res_ready;
    assign res_valid = !fifo_empty;
    assign res_ovf   = head[ENTRY_W-1];
    assign res_data  = head[31:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start is honoured only in IDLE and only with a non-zero length.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start && (len != '0)) state_next = ST_CLEAR;
            ST_CLEAR:   state_next = ST_RUN;
            ST_RUN:     if (cnt == LEN_W'(1)) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Length latch, RUN down-counter and overflow tracking across the RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        len_q <= len;
                    end
                end
                ST_CLEAR: begin
                    cnt <= len_q;
                    ovf <= 1'b0;
                end
                ST_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (acc_cout) begin
                        ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky drop flag: a CAPTURE that could not be stored; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (push && !push_ok) begin
            drop_err <= 1'b1;
        end
    end

    mac_res_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({ovf, acc_in}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_ok   (push_ok)
    );

endmodule
